router_ctrl: RTL

//  Ingress controller for the 1x3 router. Takes the byte stream from the source, decodes the

---
 rtl/router_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/router_ctrl.sv
// Ingress controller for the 1x3 router: decodes the header address, sequences FIFO writes,
// checks packet parity and raises a per-port soft_reset when an output port is not read for TIMEOUT cycles.
module router_ctrl #(
   parameter int unsigned TIMEOUT = 30,
   parameter int unsigned CNT_W   = 5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pkt_valid,
   input  logic [7:0] data_in,
   input  logic [2:0] fifo_full,
   input  logic [2:0] fifo_empty,
   input  logic [2:0] read_enb,
   output logic       busy,
   output logic [2:0] write_enb,
   output logic [7:0] fifo_data,
   output logic       lfd_state,
   output logic [2:0] vld_out,
   output logic [2:0] soft_reset,
   output logic       err
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_EMPTY,
      LOAD_HDR,
      LOAD_DATA,
      CHECK_PARITY,
      DROP
   } state_e;

   state_e           state_q, state_d;
   logic [7:0]       hdr_q, hdr_d;
   logic [1:0]       addr_q, addr_d;
   logic [6:0]       remain_q, remain_d;
   logic [7:0]       par_acc_q, par_acc_d;
   logic             par_err_q, par_err_d;
   logic             err_q, err_d;
   logic [2:0]       soft_reset_q, soft_reset_d;
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];

   logic [2:0] port_sel;
   logic       port_full;
   logic       port_empty;
   logic       port_srst;
   logic       consume;

   // Address 3 yields an all-zero select, so no port flag can ever qualify it.
   assign port_sel   = 3'b001 << addr_q;
   assign port_full  = |(fifo_full & port_sel);
   assign port_empty = |(fifo_empty & port_sel);
   assign port_srst  = |(soft_reset_q & port_sel);

   assign vld_out    = ~fifo_empty;
   assign soft_reset = soft_reset_q;
   assign err        = err_q;

   always_comb begin
      busy = 1'b0;
      unique case (state_q)
         WAIT_EMPTY, LOAD_HDR, CHECK_PARITY: busy = 1'b1;
         LOAD_DATA:                          busy = port_full;
         default:                            busy = 1'b0;
      endcase
   end

   assign consume = pkt_valid & ~busy;

   always_comb begin
      for (int unsigned p = 0; p < 3; p++) begin
         cnt_d[p]        = '0;
         soft_reset_d[p] = 1'b0;
         if (vld_out[p] && !read_enb[p]) begin
            if (cnt_q[p] == CNT_W'(TIMEOUT - 1)) soft_reset_d[p] = 1'b1;
            else                                 cnt_d[p] = cnt_q[p] + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      hdr_d     = hdr_q;
      addr_d    = addr_q;
      remain_d  = remain_q;
      par_acc_d = par_acc_q;
      par_err_d = par_err_q;
      err_d     = err_q;
      write_enb = '0;
      lfd_state = 1'b0;
      fifo_data = (state_q == LOAD_HDR) ? hdr_q : data_in;

      unique case (state_q)
         IDLE: begin
            if (consume) begin
               hdr_d     = data_in;
               addr_d    = data_in[1:0];
               par_acc_d = data_in;
               remain_d  = {1'b0, data_in[7:2]} + 7'd1;
               err_d     = 1'b0;
               if (data_in[1:0] == 2'd3)                          state_d = DROP;
               else if (|(fifo_empty & (3'b001 << data_in[1:0]))) state_d = LOAD_HDR;
               else                                               state_d = WAIT_EMPTY;
            end
         end
         WAIT_EMPTY: begin
            if (port_srst) begin
               err_d   = 1'b1;
               state_d = DROP;
            end else if (port_empty) begin
               state_d = LOAD_HDR;
            end
         end
         LOAD_HDR: begin
            if (port_srst) begin
               err_d   = 1'b1;
               state_d = DROP;
            end else if (!port_full) begin
               write_enb = port_sel;
               lfd_state = 1'b1;
               state_d   = LOAD_DATA;
            end
         end
         LOAD_DATA: begin
            // A byte accepted on the abort cycle counts toward the drop so the source stays in step.
            if (port_srst) begin
               err_d   = 1'b1;
               state_d = DROP;
               if (consume) begin
                  remain_d = remain_q - 7'd1;
                  if (remain_q == 7'd1) state_d = IDLE;
               end
            end else if (consume) begin
               write_enb = port_sel;
               remain_d  = remain_q - 7'd1;
               if (remain_q == 7'd1) begin
                  par_err_d = (par_acc_q != data_in);
                  state_d   = CHECK_PARITY;
               end else begin
                  par_acc_d = par_acc_q ^ data_in;
               end
            end
         end
         CHECK_PARITY: begin
            err_d   = par_err_q;
            state_d = IDLE;
         end
         DROP: begin
            if (consume) begin
               remain_d = remain_q - 7'd1;
               if (remain_q == 7'd1) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         hdr_q        <= '0;
         addr_q       <= '0;
         remain_q     <= '0;
         par_acc_q    <= '0;
         par_err_q    <= 1'b0;
         err_q        <= 1'b0;
         soft_reset_q <= '0;
         for (int unsigned p = 0; p < 3; p++) cnt_q[p] <= '0;
      end else begin
         state_q      <= state_d;
         hdr_q        <= hdr_d;
         addr_q       <= addr_d;
         remain_q     <= remain_d;
         par_acc_q    <= par_acc_d;
         par_err_q    <= par_err_d;
         err_q        <= err_d;
         soft_reset_q <= soft_reset_d;
         for (int unsigned p = 0; p < 3; p++) cnt_q[p] <= cnt_d[p];
      end
   end

endmodule
